// File: rtl/lsu.sv
// Load/store unit: single-outstanding bus master that issues word-aligned
// requests, steers byte lanes for stores and aligns/extends load data.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_en_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        lsu_done_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        MISALIGN
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        we_q, sign_q;

    logic        misaligned;
    logic        issue;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_we;
    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign misaligned = (lsu_size_i == 2'b01) ? addr_i[0]
                      : (lsu_size_i[1] ? |addr_i[1:0] : 1'b0);

    // rst_n gates the combinational issue path so nothing leaks out in reset
    assign issue = rst_n & (state == IDLE) & lsu_en_i & ~misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && lsu_en_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                size_q  <= lsu_size_i;
                we_q    <= lsu_we_i;
                sign_q  <= lsu_sign_ext_i;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        lsu_done_o   = 1'b0;
        misaligned_o = 1'b0;
        case (state)
            IDLE: begin
                if (lsu_en_i) begin
                    if (misaligned)      state_nxt = MISALIGN;
                    else if (data_gnt_i) state_nxt = WAIT_RVALID;
                    else                 state_nxt = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (data_gnt_i) state_nxt = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    lsu_done_o = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            MISALIGN: begin
                lsu_done_o   = 1'b1;
                misaligned_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue cycle drives straight from inputs; afterwards from the registers
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
            cur_size  = lsu_size_i;
            cur_we    = lsu_we_i;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_we    = we_q;
        end
    end

    always_comb begin
        case (cur_size)
            2'b00: begin
                be         = 4'b0001 << cur_addr[1:0];
                lane_wdata = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be         = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cur_wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = cur_wdata;
            end
        endcase
    end

    assign data_req_o   = issue | (state == WAIT_GNT);
    assign data_addr_o  = data_req_o ? {cur_addr[31:2], 2'b00} : 32'h0;
    assign data_we_o    = data_req_o & cur_we;
    assign data_be_o    = data_req_o ? be : 4'b0000;
    assign data_wdata_o = data_req_o ? lane_wdata : 32'h0;

    assign shifted = data_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data = sign_q ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
            2'b01:   load_data = sign_q ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign rdata_o = (state == WAIT_RVALID && data_rvalid_i && !we_q)
                   ? load_data : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of single transactions plus
// hand-written reset, enable-drop and spurious-handshake sequences.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_en_i, lsu_we_i, lsu_sign_ext_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] addr_i, wdata_i;
    logic        lsu_done_o, misaligned_o;
    logic [31:0] rdata_o;
    logic        data_req_o, data_gnt_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_en_i(lsu_en_i), .lsu_we_i(lsu_we_i),
        .lsu_size_i(lsu_size_i), .lsu_sign_ext_i(lsu_sign_ext_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .lsu_done_o(lsu_done_o), .misaligned_o(misaligned_o),
        .rdata_o(rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [31:0] erdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        lsu_en_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_sign_ext_i = 0;
        addr_i = 0; wdata_i = 0; data_gnt_i = 0;
        data_rvalid_i = 0; data_rdata_i = 0;
    endtask

    // Garbage on the request inputs after issue: bus side must use registers
    task automatic scramble();
        addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5A5A_5A5A;
        lsu_size_i = 2'b11; lsu_we_i = ~lsu_we_i;
        lsu_sign_ext_i = ~lsu_sign_ext_i;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        logic  we;
        t = $sformatf("v%0d", idx);
        we = v.we;
        @(posedge clk); #1;
        lsu_en_i = 1; lsu_we_i = v.we; lsu_size_i = v.size;
        lsu_sign_ext_i = v.sign; addr_i = v.addr; wdata_i = v.wdata;
        data_gnt_i = (v.dly == 0) && !v.mis;
        if (v.mis) begin
            @(negedge clk);
            chk({t, "_noreq"}, {31'b0, data_req_o}, 0);
            chk({t, "_nodone"}, {31'b0, lsu_done_o}, 0);
            @(posedge clk); #1;
            scramble();
            @(negedge clk);
            chk({t, "_done"}, {31'b0, lsu_done_o}, 1);
            chk({t, "_mis"}, {31'b0, misaligned_o}, 1);
            chk({t, "_rdata"}, rdata_o, 0);
            chk({t, "_noreq2"}, {31'b0, data_req_o}, 0);
        end else begin
            for (int c = 0; c <= v.dly; c++) begin
                @(negedge clk);
                chk({t, "_req"}, {31'b0, data_req_o}, 1);
                chk({t, "_addr"}, data_addr_o, v.eaddr);
                chk({t, "_be"}, {28'b0, data_be_o}, {28'b0, v.be});
                chk({t, "_we"}, {31'b0, data_we_o}, {31'b0, we});
                if (we) chk({t, "_wdata"}, data_wdata_o, v.ewdata);
                chk({t, "_nodone"}, {31'b0, lsu_done_o}, 0);
                @(posedge clk); #1;
                scramble();
                data_gnt_i = (c + 1 == v.dly);
            end
            data_gnt_i = 0;
            data_rvalid_i = 1;
            data_rdata_i = v.rdata;
            @(negedge clk);
            chk({t, "_rv_noreq"}, {31'b0, data_req_o}, 0);
            chk({t, "_done"}, {31'b0, lsu_done_o}, 1);
            chk({t, "_nomis"}, {31'b0, misaligned_o}, 0);
            chk({t, "_rdata"}, rdata_o, v.erdata);
        end
        @(posedge clk); #1;
        idle_inputs();
        data_rdata_i = 32'h7777_7777;
        @(negedge clk);
        chk({t, "_after_done"}, {31'b0, lsu_done_o}, 0);
        chk({t, "_after_rdata"}, rdata_o, 0);
    endtask

    initial begin
        //          we size sign addr          wdata         rdata         dly mis be       eaddr         ewdata        erdata
        vecs[0]  = '{0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{0, 2'b00, 1, 32'h103, 32'h0,        32'h80000000, 0, 0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{0, 2'b00, 0, 32'h103, 32'h0,        32'h80000000, 0, 0, 4'b1000, 32'h100, 32'h0,        32'h00000080};
        vecs[3]  = '{1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h55555555, 3, 0, 4'b1100, 32'h200, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[5]  = '{0, 2'b01, 1, 32'h102, 32'h0,        32'h80010000, 0, 0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{0, 2'b01, 0, 32'h100, 32'h0,        32'h1234F00D, 1, 0, 4'b0011, 32'h100, 32'h0,        32'h0000F00D};
        vecs[7]  = '{1, 2'b00, 0, 32'h301, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'h300, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{1, 2'b10, 0, 32'h400, 32'hCAFEBABE, 32'h0,        2, 0, 4'b1111, 32'h400, 32'hCAFEBABE, 32'h0};
        vecs[9]  = '{0, 2'b01, 1, 32'h103, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[10] = '{0, 2'b00, 1, 32'h101, 32'h0,        32'h00007F00, 0, 0, 4'b0010, 32'h100, 32'h0,        32'h0000007F};
        vecs[11] = '{0, 2'b11, 1, 32'h108, 32'h0,        32'h80000000, 1, 0, 4'b1111, 32'h108, 32'h0,        32'h80000000};
        vecs[12] = '{1, 2'b11, 0, 32'h10A, 32'h11223344, 32'h0,        0, 1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[13] = '{0, 2'b00, 1, 32'h102, 32'h0,        32'h00FF0000, 0, 0, 4'b0100, 32'h100, 32'h0,        32'hFFFFFFFF};

        idle_inputs();
        rst_n = 0;
        // Request inputs active during reset must not reach the bus
        lsu_en_i = 1; addr_i = 32'h100; lsu_size_i = 2'b10; data_gnt_i = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, data_req_o}, 0);
        chk("rst_done", {31'b0, lsu_done_o}, 0);
        chk("rst_be", {28'b0, data_be_o}, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_rdata", rdata_o, 0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Spurious rvalid and gnt in IDLE are ignored
        @(posedge clk); #1;
        data_rvalid_i = 1; data_gnt_i = 1; data_rdata_i = 32'h1;
        @(negedge clk);
        chk("spur_done", {31'b0, lsu_done_o}, 0);
        chk("spur_req", {31'b0, data_req_o}, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("spur_done2", {31'b0, lsu_done_o}, 0);

        // Enable drops while waiting for grant: transaction still completes
        @(posedge clk); #1;
        lsu_en_i = 1; lsu_size_i = 2'b10; addr_i = 32'h500;
        @(posedge clk); #1;
        lsu_en_i = 0; addr_i = 32'h0;
        @(negedge clk);
        chk("endrop_req", {31'b0, data_req_o}, 1);
        chk("endrop_addr", data_addr_o, 32'h500);
        @(posedge clk); #1;
        data_gnt_i = 1;
        @(posedge clk); #1;
        data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        chk("endrop_done", {31'b0, lsu_done_o}, 1);
        chk("endrop_rdata", rdata_o, 32'h0BADF00D);
        @(posedge clk); #1;
        idle_inputs();

        // Reset in WAIT_RVALID: later rvalid must not produce done
        @(posedge clk); #1;
        lsu_en_i = 1; lsu_size_i = 2'b10; addr_i = 32'h600; data_gnt_i = 1;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 0;
        #1;
        chk("rstrv_req", {31'b0, data_req_o}, 0);
        data_rvalid_i = 1; data_rdata_i = 32'hFFFF_0000;
        @(negedge clk);
        chk("rstrv_done", {31'b0, lsu_done_o}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rstrv_done2", {31'b0, lsu_done_o}, 0);
        chk("rstrv_rdata", rdata_o, 0);
        @(posedge clk); #1;
        idle_inputs();

        // Reset in WAIT_GNT drops the request at once
        @(posedge clk); #1;
        lsu_en_i = 1; lsu_size_i = 2'b10; addr_i = 32'h700;
        @(posedge clk); #1;
        lsu_en_i = 0;
        @(negedge clk);
        chk("rstg_req_pre", {31'b0, data_req_o}, 1);
        rst_n = 0;
        #1;
        chk("rstg_req", {31'b0, data_req_o}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        data_gnt_i = 1; data_rvalid_i = 1;
        @(negedge clk);
        chk("rstg_done", {31'b0, lsu_done_o}, 0);
        chk("rstg_req2", {31'b0, data_req_o}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
